// File: rtl/expr_recognizer_if.sv
// Character stream in, recognition status out, between the character source and the evaluator.
interface expr_recognizer_if #(
    parameter int CNT_W = 8
);
    logic [7:0]       in;
    logic             in_valid;
    logic             out;
    logic             err;
    logic             done;
    logic             ok;
    logic [CNT_W-1:0] opnd_cnt;

    modport master (output in, in_valid, input out, err, done, ok, opnd_cnt);
    modport slave  (input in, in_valid, output out, err, done, ok, opnd_cnt);
endinterface

// File: rtl/expr_recognizer.sv
// Recognizes "operand (op operand)*" terminated by '='.
// Operands are multi-digit decimal numbers; after an error the FSM waits for '=' to recover.
module expr_recognizer #(
    parameter int MAX_DIGITS = 4,
    parameter int MODE       = 0,
    parameter int CNT_W      = 8
) (
    input logic              clk,
    input logic              clr,
    expr_recognizer_if.slave bus
);
    localparam int DW = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {START, NUM, OPR, ERR} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;

    logic             is_digit, is_term, is_op;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        is_digit = (bus.in >= 8'h30) && (bus.in <= 8'h39);
        is_term  = (bus.in == 8'h3D);
        if (MODE == 0) is_op = !is_digit && !is_term;
        else           is_op = (bus.in == 8'h2B) || (bus.in == 8'h2D) ||
                               (bus.in == 8'h2A) || (bus.in == 8'h2F);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = err_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        if (bus.in_valid) begin
            out_d = 1'b0;
            if (is_term) begin
                // Only a terminator right after a digit closes a well-formed expression.
                state_d = START;
                done_d  = 1'b1;
                ok_d    = (state_q == NUM);
                err_d   = 1'b0;
                cnt_d   = '0;
                dcnt_d  = '0;
            end else begin
                case (state_q)
                    START, OPR: begin
                        if (is_digit) begin
                            state_d = NUM;
                            dcnt_d  = DW'(1);
                            cnt_d   = cnt_inc;
                            out_d   = 1'b1;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                    NUM: begin
                        if (is_digit && (dcnt_q < DW'(MAX_DIGITS))) begin
                            dcnt_d = dcnt_q + DW'(1);
                            out_d  = 1'b1;
                        end else if (is_op && !is_digit) begin
                            state_d = OPR;
                        end else begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end
                    end
                    ERR: err_d = 1'b1;
                    default: begin
                        state_d = START;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        dcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= START;
            dcnt_q  <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.err      = err_q;
    assign bus.done     = done_q;
    assign bus.ok       = ok_q;
    assign bus.opnd_cnt = cnt_q;
endmodule

// File: tb/tb_expr_recognizer.sv
// Drives two differently parameterized recognizers with one character stream and
// compares every output against a token-level reference model after each edge.
module tb_expr_recognizer;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance 0: MODE 0, 2-digit operands, 2-bit counter. Instance 1: MODE 1, 4 digits, 8 bits.
    expr_recognizer_if #(.CNT_W(2)) b0 ();
    expr_recognizer_if #(.CNT_W(8)) b1 ();

    expr_recognizer #(.MAX_DIGITS(2), .MODE(0), .CNT_W(2)) dut0 (.clk(clk), .clr(clr), .bus(b0.slave));
    expr_recognizer #(.MAX_DIGITS(4), .MODE(1), .CNT_W(8)) dut1 (.clk(clk), .clr(clr), .bus(b1.slave));

    int p_mode [2] = '{0, 1};
    int p_maxd [2] = '{2, 4};
    int p_cmax [2] = '{3, 255};

    // Model: count of operands seen, length of current operand, whether the last token was an operator.
    bit m_err [2];
    int m_cnt [2];
    int m_len [2];
    bit m_lop [2];
    bit m_out [2];
    bit m_done[2];
    bit m_ok  [2];

    function automatic int cls(input int mode, input logic [7:0] c);
        if (c >= "0" && c <= "9") return 0;
        if (c == "=") return 1;
        if (mode == 0) return 2;
        if (c == "+" || c == "-" || c == "*" || c == "/") return 2;
        return 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_cnt[k] = 0; m_len[k] = 0; m_lop[k] = 0;
            m_out[k] = 0; m_done[k] = 0; m_ok[k] = 0;
        end
    endtask

    task automatic model_char(input int k, input logic [7:0] c);
        int t;
        t = cls(p_mode[k], c);
        m_done[k] = 0;
        if (t == 1) begin
            m_done[k] = 1;
            m_ok[k]   = !m_err[k] && m_cnt[k] > 0 && !m_lop[k];
            m_err[k] = 0; m_cnt[k] = 0; m_len[k] = 0; m_lop[k] = 0;
        end else if (!m_err[k]) begin
            if (t == 0) begin
                if (m_cnt[k] == 0 || m_lop[k]) begin
                    m_cnt[k]++; m_len[k] = 1; m_lop[k] = 0;
                end else if (m_len[k] == p_maxd[k]) m_err[k] = 1;
                else m_len[k]++;
            end else if (t == 2) begin
                if (m_cnt[k] == 0 || m_lop[k]) m_err[k] = 1;
                else m_lop[k] = 1;
            end else m_err[k] = 1;
        end
        m_out[k] = !m_err[k] && m_cnt[k] > 0 && !m_lop[k];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        int sat0, sat1;
        sat0 = (m_cnt[0] > p_cmax[0]) ? p_cmax[0] : m_cnt[0];
        sat1 = (m_cnt[1] > p_cmax[1]) ? p_cmax[1] : m_cnt[1];
        chk({where, " d0.out"},  32'(b0.out),      32'(m_out[0]));
        chk({where, " d0.err"},  32'(b0.err),      32'(m_err[0]));
        chk({where, " d0.done"}, 32'(b0.done),     32'(m_done[0]));
        chk({where, " d0.ok"},   32'(b0.ok),       32'(m_ok[0]));
        chk({where, " d0.cnt"},  32'(b0.opnd_cnt), 32'(sat0));
        chk({where, " d1.out"},  32'(b1.out),      32'(m_out[1]));
        chk({where, " d1.err"},  32'(b1.err),      32'(m_err[1]));
        chk({where, " d1.done"}, 32'(b1.done),     32'(m_done[1]));
        chk({where, " d1.ok"},   32'(b1.ok),       32'(m_ok[1]));
        chk({where, " d1.cnt"},  32'(b1.opnd_cnt), 32'(sat1));
    endtask

    task automatic step(input string where, input logic [7:0] c, input bit v);
        b0.in = c; b1.in = c;
        b0.in_valid = v; b1.in_valid = v;
        if (!clr) model_reset();
        else for (int k = 0; k < 2; k++) begin
            if (v) model_char(k, c);
            else m_done[k] = 0;
        end
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    task automatic run_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s, s[i], 1'b1);
    endtask

    string alpha = "0123456789+-*/=a %";

    initial begin
        b0.in = 8'h00; b1.in = 8'h00; b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        clr = 1'b0;
        step("reset", 8'h00, 1'b0);
        step("reset_v", "5", 1'b1);
        clr = 1'b1;

        run_str("12+345=");
        run_str("12345=");
        run_str("3a4=");
        run_str("7+=");
        run_str("++=");
        step("idle9", "9", 1'b1);
        step("idle0", "x", 1'b0);
        step("idle1", "x", 1'b0);
        step("idle+", "+", 1'b1);
        run_str("=");
        run_str("1+2+3+4+5=");
        run_str("=");
        run_str("56");
        clr = 1'b0;
        step("midrst", "*", 1'b1);
        clr = 1'b1;
        run_str("8=");

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] c;
            bit v;
            if ($urandom_range(0, 19) == 0) c = 8'($urandom());
            else c = alpha[$urandom_range(0, alpha.len() - 1)];
            v = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) != 0);
            step("rand", c, v);
        end
        clr = 1'b1;
        run_str("=");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
